// File: rtl/key_ctrl.sv
// key_ctrl: turns PS/2 scan-code events into game-state, jump, duck and restart controls.
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   kb_data[9:0]  : {extended, break, code} scan-code event
//   kb_ready      : one-cycle strobe qualifying kb_data
//   game_over     : collision level from the game core
//   game_state    : 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER (registered)
//   jump_pulse    : one-cycle jump command (registered)
//   duck          : duck level (registered)
//   restart_pulse : one-cycle game-core reset request (registered)
module key_ctrl #(
    parameter logic [7:0] JUMP_CODE     = 8'h29,
    parameter logic [7:0] UP_CODE       = 8'h75,
    parameter logic [7:0] DUCK_CODE     = 8'h72,
    parameter logic [7:0] START_CODE    = 8'h5A,
    parameter logic [7:0] PAUSE_CODE    = 8'h4D,
    parameter int         REPEAT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] kb_data,
    input  logic       kb_ready,
    input  logic       game_over,
    output logic [1:0] game_state,
    output logic       jump_pulse,
    output logic       duck,
    output logic       restart_pulse
);
    localparam int CW = $clog2(REPEAT_CYCLES);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;
    state_t        state_q, state_d;
    logic          jump_held_q, jump_held_d, duck_held_q, duck_held_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          jump_pulse_q, jump_pulse_d, duck_q, duck_d, restart_q, restart_d;
    logic          ext, brk, jump_ev, duck_ev, start_mk, pause_mk, jump_press, run, rep_fire;
    logic [7:0]    code;
    assign ext        = kb_data[9];
    assign brk        = kb_data[8];
    assign code       = kb_data[7:0];
    // Space and Up are both jump keys; they share one held flag
    assign jump_ev    = kb_ready && ((!ext && code == JUMP_CODE) || (ext && code == UP_CODE));
    assign duck_ev    = kb_ready && ext && code == DUCK_CODE;
    assign start_mk   = kb_ready && !ext && !brk && code == START_CODE;
    assign pause_mk   = kb_ready && !ext && !brk && code == PAUSE_CODE;
    // typematic repeats arrive as makes while already held and are not new presses
    assign jump_press = jump_ev && !brk && !jump_held_q;
    assign run        = state_q == RUN;
    assign rep_fire   = run && jump_held_q && cnt_q == CW'(REPEAT_CYCLES - 1);
    always_comb begin
        state_d   = state_q;
        restart_d = 1'b0;
        unique case (state_q)
            IDLE:    if (jump_press || start_mk) begin
                         state_d   = RUN;
                         restart_d = 1'b1;
                     end
            RUN:     state_d = game_over ? OVER : pause_mk ? PAUSE : RUN;
            PAUSE:   state_d = pause_mk ? RUN : PAUSE;
            OVER:    if (start_mk) begin
                         state_d   = RUN;
                         restart_d = 1'b1;
                     end
            default: state_d = IDLE;
        endcase
    end
    assign jump_held_d  = jump_ev ? !brk : jump_held_q;
    assign duck_held_d  = duck_ev ? !brk : duck_held_q;
    assign cnt_d        = (jump_press || !run || !jump_held_q || rep_fire) ? '0 : cnt_q + CW'(1);
    // the press that starts the game does not jump because state is still IDLE
    assign jump_pulse_d = (run && jump_press) || rep_fire;
    assign duck_d       = duck_held_q && run;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            jump_held_q  <= 1'b0;
            duck_held_q  <= 1'b0;
            cnt_q        <= '0;
            jump_pulse_q <= 1'b0;
            duck_q       <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            jump_held_q  <= jump_held_d;
            duck_held_q  <= duck_held_d;
            cnt_q        <= cnt_d;
            jump_pulse_q <= jump_pulse_d;
            duck_q       <= duck_d;
            restart_q    <= restart_d;
        end
    end
    assign game_state    = state_q;
    assign jump_pulse    = jump_pulse_q;
    assign duck          = duck_q;
    assign restart_pulse = restart_q;
endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: scoreboard bench for key_ctrl with a behavioural reference model.
module tb_key_ctrl;
    localparam int R = 8;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_OVER = 2'b11;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] kb_data;
    logic       kb_ready;
    logic       game_over;
    logic [1:0] game_state;
    logic       jump_pulse, duck, restart_pulse;
    int         checks = 0;
    int         errors = 0;
    int         jp_cnt = 0;
    int         cyc_no = 0;
    logic [4:0] exp_q[$];
    logic [1:0] m_state;
    logic       m_jh, m_dh;
    int         m_cnt;

    key_ctrl #(.REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n), .kb_data(kb_data), .kb_ready(kb_ready), .game_over(game_over),
        .game_state(game_state), .jump_pulse(jump_pulse), .duck(duck), .restart_pulse(restart_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = S_IDLE;
        m_jh    = 1'b0;
        m_dh    = 1'b0;
        m_cnt   = 0;
    endtask

    // Expected outputs after the coming clock edge, from the key/state rules.
    task automatic model_step(input logic r, input logic [9:0] d, input logic g, output logic [4:0] e);
        logic       is_jump, is_duck, press, start, pause, jp, dk, rs;
        logic [1:0] ns;
        is_jump = r && ((!d[9] && d[7:0] == 8'h29) || (d[9] && d[7:0] == 8'h75));
        is_duck = r && d[9] && d[7:0] == 8'h72;
        start   = r && !d[9] && !d[8] && d[7:0] == 8'h5A;
        pause   = r && !d[9] && !d[8] && d[7:0] == 8'h4D;
        press   = is_jump && !d[8] && !m_jh;
        ns = m_state;
        rs = 1'b0;
        if (m_state == S_IDLE && (press || start)) begin
            ns = S_RUN;
            rs = 1'b1;
        end else if (m_state == S_RUN && g) ns = S_OVER;
        else if (m_state == S_RUN && pause) ns = S_PAUSE;
        else if (m_state == S_PAUSE && pause) ns = S_RUN;
        else if (m_state == S_OVER && start) begin
            ns = S_RUN;
            rs = 1'b1;
        end
        jp = m_state == S_RUN && press;
        if (press) m_cnt = 0;
        else if (m_state == S_RUN && m_jh) begin
            if (m_cnt == R - 1) begin
                m_cnt = 0;
                jp = 1'b1;
            end else m_cnt = m_cnt + 1;
        end else m_cnt = 0;
        dk = m_dh && m_state == S_RUN;
        if (is_jump) m_jh = !d[8];
        if (is_duck) m_dh = !d[8];
        m_state = ns;
        e = {ns, jp, dk, rs};
    endtask

    task automatic cyc(input logic r, input logic [9:0] d, input logic g);
        logic [4:0] e;
        @(negedge clk);
        kb_ready  = r;
        kb_data   = d;
        game_over = g;
        model_step(r, d, g, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 10'h000, 1'b0);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({game_state, jump_pulse, duck, restart_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL %s: outputs=%b required=00000", name, {game_state, jump_pulse, duck, restart_pulse});
        end
    endtask

    task automatic check_cnt(input string name, input int want);
        checks++;
        if (jp_cnt != want) begin
            errors++;
            $display("FAIL %s: jump pulses=%0d required=%0d", name, jp_cnt, want);
        end
    endtask

    initial begin
        logic [4:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (jump_pulse) jp_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {game_state, jump_pulse, duck, restart_pulse};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs@%0d: {state,jump,duck,restart}=%b required=%b", cyc_no, a, e);
                end
            end
        end
    end

    initial begin
        logic [7:0] pool[6];
        logic [7:0] code;
        int         idx;
        pool = '{8'h29, 8'h75, 8'h72, 8'h5A, 8'h4D, 8'h11};
        rst_n = 1'b0;
        kb_ready = 1'b0;
        kb_data = '0;
        game_over = 1'b0;
        model_reset();
        #12;
        check_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        cyc(1'b1, 10'h029, 1'b0);
        idle(3);
        cyc(1'b1, 10'h129, 1'b0);
        idle(2);
        jp_cnt = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 10'h029, 1'b0);
        cyc(1'b1, 10'h129, 1'b0);
        idle(3);
        check_cnt("single_press", 1);
        jp_cnt = 0;
        cyc(1'b1, 10'h275, 1'b0);
        idle(29);
        cyc(1'b1, 10'h375, 1'b0);
        idle(12);
        check_cnt("auto_repeat", 4);
        cyc(1'b1, 10'h272, 1'b0);
        idle(2);
        cyc(1'b1, 10'h04D, 1'b0);
        idle(2);
        cyc(1'b1, 10'h04D, 1'b0);
        idle(2);
        cyc(1'b1, 10'h372, 1'b0);
        idle(2);
        cyc(1'b1, 10'h04D, 1'b1);
        idle(2);
        cyc(1'b1, 10'h05A, 1'b0);
        idle(2);
        cyc(1'b1, 10'h029, 1'b0);
        cyc(1'b1, 10'h272, 1'b0);
        idle(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_hold");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2);
        cyc(1'b1, 10'h05A, 1'b0);
        jp_cnt = 0;
        idle(20);
        check_cnt("no_repeat_after_reset", 0);
        cyc(1'b1, 10'h029, 1'b0);
        idle(2);
        check_cnt("press_after_reset", 1);
        cyc(1'b1, 10'h129, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            idx  = $urandom_range(0, 6);
            code = idx == 6 ? 8'($urandom) : pool[idx];
            cyc(1'($urandom_range(0, 1)),
                {1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), code},
                1'($urandom_range(0, 39) == 0));
        end
        idle(2);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
